// File: rtl/fll_bitclk_compare.sv
// Frequency comparator for the I2S FLL: counts master/local bit-clock edges over a window of
// master edges and flags when local leads or lags by more than a threshold.
module fll_bitclk_compare #(
  parameter logic [16:0]          MODULE_OFFSET = 17'h01000,
  parameter int unsigned          CNT_WIDTH     = 16,
  parameter logic [CNT_WIDTH-1:0] DEF_WINDOW    = CNT_WIDTH'(1024),
  parameter logic [7:0]           DEF_THRESH    = 8'd2
) (
  input  logic        WBs_CLK_i,
  input  logic        WBs_RST_i,
  input  logic [16:0] WBs_ADR_i,
  input  logic        WBs_CYC_i,
  input  logic [3:0]  WBs_BYTE_STB_i,
  input  logic        WBs_WE_i,
  input  logic        WBs_STB_i,
  input  logic [31:0] WBs_DAT_i,
  output logic [31:0] WBs_DAT_o,
  output logic        WBs_ACK_o,
  input  logic        bitclk_master,
  input  logic        bitclk_local,
  output logic        Interrupt_speedup,
  output logic        Interrupt_slowdown
);

  localparam logic [9:0] AddrCtrl   = 10'h000;
  localparam logic [9:0] AddrWindow = 10'h001;
  localparam logic [9:0] AddrStatus = 10'h002;
  localparam logic [9:0] AddrDiff   = 10'h003;
  localparam logic [9:0] AddrLocal  = 10'h004;

  typedef enum logic [1:0] {StIdle, StCount, StEval} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d, lcnt_q, lcnt_d, win_eff;
  logic [CNT_WIDTH-1:0] window_q, window_wr, local_q;
  logic [CNT_WIDTH:0]   diff_q;
  logic signed [CNT_WIDTH:0] diff_new, thr_s;
  logic [7:0]           thresh_q, thresh_wr;
  logic                 en_q, en_wr, speedup_q, slowdown_q, win_done_q;
  logic [2:0]           m_sync_q, l_sync_q, w1c;
  logic                 m_edge, l_edge, eval, set_speed, set_slow;
  logic                 req, wr, ack_q;
  logic [31:0]          dat_q, rdata;
  logic [9:0]           word;
  logic                 unused_in;

  assign unused_in = ^{WBs_ADR_i[1:0], WBs_DAT_i[31:16], WBs_BYTE_STB_i[3:2]};

  assign word = WBs_ADR_i[11:2];
  assign req  = (WBs_ADR_i[16:12] == MODULE_OFFSET[16:12]) & WBs_CYC_i & WBs_STB_i;
  assign wr   = req & WBs_WE_i & ack_q;

  // Pulse is high for one clock after the synchronised level rises.
  assign m_edge = m_sync_q[1] & ~m_sync_q[2];
  assign l_edge = l_sync_q[1] & ~l_sync_q[2];

  assign win_eff  = (window_q < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : window_q;
  assign diff_new = signed'({1'b0, lcnt_q}) - signed'({1'b0, mcnt_q});
  assign thr_s    = signed'((CNT_WIDTH+1)'(thresh_q));
  assign set_speed = eval && (diff_new < -thr_s);
  assign set_slow  = eval && (diff_new > thr_s);

  assign en_wr     = WBs_BYTE_STB_i[0] ? WBs_DAT_i[0] : en_q;
  assign thresh_wr = WBs_BYTE_STB_i[1] ? WBs_DAT_i[15:8] : thresh_q;
  assign w1c = (wr && word == AddrStatus && WBs_BYTE_STB_i[0]) ? WBs_DAT_i[2:0] : 3'b000;

  always_comb begin
    window_wr = window_q;
    for (int i = 0; i < CNT_WIDTH; i++) begin
      if (WBs_BYTE_STB_i[i/8]) window_wr[i] = WBs_DAT_i[i];
    end
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    lcnt_d  = lcnt_q;
    eval    = 1'b0;
    unique case (state_q)
      StIdle: begin
        mcnt_d = '0;
        lcnt_d = '0;
        if (en_q) state_d = StCount;
      end
      StCount: begin
        if (m_edge) mcnt_d = mcnt_q + CNT_WIDTH'(1);
        if (l_edge && lcnt_q != '1) lcnt_d = lcnt_q + CNT_WIDTH'(1);
        if (mcnt_d == win_eff) state_d = StEval;
      end
      StEval: begin
        eval    = 1'b1;
        mcnt_d  = CNT_WIDTH'(m_edge);
        lcnt_d  = CNT_WIDTH'(l_edge);
        state_d = StCount;
      end
      default: state_d = StIdle;
    endcase
    // Disabling discards any partial window, whatever the state.
    if (!en_q) begin
      state_d = StIdle;
      mcnt_d  = '0;
      lcnt_d  = '0;
    end
  end

  always_comb begin
    rdata = 32'hBADFABAC;
    case (word)
      AddrCtrl:   rdata = {16'h0, thresh_q, 7'h0, en_q};
      AddrWindow: rdata = 32'(window_q);
      AddrStatus: rdata = {29'h0, win_done_q, slowdown_q, speedup_q};
      AddrDiff:   rdata = {{(31-CNT_WIDTH){diff_q[CNT_WIDTH]}}, diff_q};
      AddrLocal:  rdata = 32'(local_q);
      default:    rdata = 32'hBADFABAC;
    endcase
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_i) begin
    if (!WBs_RST_i) begin
      state_q    <= StIdle;
      mcnt_q     <= '0;
      lcnt_q     <= '0;
      m_sync_q   <= '0;
      l_sync_q   <= '0;
      en_q       <= 1'b0;
      thresh_q   <= DEF_THRESH;
      window_q   <= DEF_WINDOW;
      speedup_q  <= 1'b0;
      slowdown_q <= 1'b0;
      win_done_q <= 1'b0;
      diff_q     <= '0;
      local_q    <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcnt_q   <= mcnt_d;
      lcnt_q   <= lcnt_d;
      m_sync_q <= {m_sync_q[1:0], bitclk_master};
      l_sync_q <= {l_sync_q[1:0], bitclk_local};
      ack_q    <= req & ~ack_q;
      if (req && !ack_q) dat_q <= rdata;
      if (wr && word == AddrCtrl) begin
        en_q     <= en_wr;
        thresh_q <= thresh_wr;
      end
      if (wr && word == AddrWindow) window_q <= window_wr;
      // A set in the same cycle as a W1C wins.
      speedup_q  <= (speedup_q & ~w1c[0]) | set_speed;
      slowdown_q <= (slowdown_q & ~w1c[1]) | set_slow;
      win_done_q <= (win_done_q & ~w1c[2]) | eval;
      if (eval) begin
        diff_q  <= diff_new;
        local_q <= lcnt_q;
      end
    end
  end

  assign WBs_ACK_o          = ack_q;
  assign WBs_DAT_o          = dat_q;
  assign Interrupt_speedup  = speedup_q;
  assign Interrupt_slowdown = slowdown_q;

endmodule
